// File: rtl/fill_rect_engine_if.sv
// Control and plot-port bundle for fill_rect_engine.
//   start, abort, mode, colour, x0, y0, x1, y1 : request from the top-level controller
//   busy, done                                 : status back to the controller
//   vga_x, vga_y, vga_colour, vga_plot         : pixel write port to the VGA adapter
// modport slave  : engine side (drives status and plot port)
// modport master : controller side (drives the request, observes everything)
interface fill_rect_engine_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
) ();
  logic           start;
  logic           abort;
  logic [1:0]     mode;
  logic [C_W-1:0] colour;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y1;
  logic           busy;
  logic           done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic           vga_plot;

  modport slave (
    input  start, abort, mode, colour, x0, y0, x1, y1,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output start, abort, mode, colour, x0, y0, x1, y1,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/fill_rect_engine.sv
// fill_rect_engine: paints a clipped rectangle into the VGA adapter frame
// buffer, one pixel per clock, in one of four colour patterns
// (0 solid, 1 column stripes, 2 row stripes, 3 checkerboard).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : fill_rect_engine_if.slave (request, busy/done, VGA plot port)
// Scan order is column-major: y runs fastest, then x.
module fill_rect_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int CHK_LOG  = 3
) (
  input  logic               clk,
  input  logic               rst,
  fill_rect_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLOT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic [X_W-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [C_W-1:0] vga_colour_q, vga_colour_d;
  logic           vga_plot_q, vga_plot_d;

  logic [X_W-1:0] xe_s;
  logic [Y_W-1:0] ye_s;
  logic           empty_s;
  logic           last_row_s;
  logic           last_col_s;
  logic [C_W-1:0] pix_colour_s;

  // Clip the latched corner to the screen and classify the current position.
  // The last-column test is an explicit compare, so x never has to wrap.
  always_comb begin
    xe_s       = (x1_q > X_MAX) ? X_MAX : x1_q;
    ye_s       = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    empty_s    = (x0_q > xe_s) || (y0_q > ye_s);
    last_row_s = (y_q == ye_s);
    last_col_s = (x_q == xe_s);
  end

  // Pattern colour for the pixel at the current counters.
  always_comb begin
    pix_colour_s = colour_q;
    case (mode_q)
      2'd0:    pix_colour_s = colour_q;
      2'd1:    pix_colour_s = C_W'(x_q) + colour_q;
      2'd2:    pix_colour_s = C_W'(y_q) + colour_q;
      2'd3:    pix_colour_s = (x_q[CHK_LOG] ^ y_q[CHK_LOG]) ? ~colour_q : colour_q;
      default: pix_colour_s = colour_q;
    endcase
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    colour_d     = colour_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    x_d          = x_q;
    y_d          = y_q;
    vga_plot_d   = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d   = bus.mode;
          colour_d = bus.colour;
          x0_d     = bus.x0;
          y0_d     = bus.y0;
          x1_d     = bus.x1;
          y1_d     = bus.y1;
          state_d  = LOAD;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (empty_s) begin
          state_d = DONE;
        end else begin
          state_d = PLOT;
          x_d     = x0_q;
          y_d     = y0_q;
        end
      end
      PLOT: begin
        // Abort beats the pixel in flight, including the final one.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          vga_plot_d   = 1'b1;
          vga_x_d      = x_q;
          vga_y_d      = y_q;
          vga_colour_d = pix_colour_s;
          if (last_row_s) begin
            y_d = y0_q;
            if (last_col_s) begin
              state_d = DONE;
            end else begin
              x_d = x_q + X_W'(1);
            end
          end else begin
            y_d = y_q + Y_W'(1);
          end
        end
      end
      DONE: begin
        // Stay until done has been visible for at least one cycle, and for
        // as long as start is held, so a held start cannot retrigger.
        if (bus.start || !done_q) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags: busy tracks the state exactly; done follows the first DONE
  // cycle, which lands it one cycle after the last registered plot.
  always_comb begin
    busy_d = (state_d == LOAD) || (state_d == PLOT);
    done_d = (state_q == DONE) && (state_d == DONE);
  end

  // State, latched request, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= 2'd0;
      colour_q     <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      colour_q     <= colour_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x_q          <= x_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;

endmodule

// File: doc/fill_rect_engine.md
Name: fill_rect_engine

Overview:
- Parametrised successor to the fixed full-screen fill: paints a clipped rectangle into the VGA adapter frame buffer, one pixel per clock.
- Four colour modes: solid, column stripes, row stripes, checkerboard.
- Sits between top-level control (KEY/SW decode) and the VGA adapter plot port (vga_x/vga_y/vga_colour/vga_plot).
- Uses a start/done handshake so a top-level FSM can chain it with other draw engines.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- X_W, 8, x coordinate width; must satisfy 2^X_W >= SCREEN_W.
- Y_W, 7, y coordinate width; must satisfy 2^Y_W >= SCREEN_H.
- C_W, 3, colour width.
- CHK_LOG, 3, log2 of checkerboard square size.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a fill; sampled only in IDLE.
- abort  in  1  cancel an in-progress fill.
- mode  in  2  fill pattern: 0 solid, 1 column stripes, 2 row stripes, 3 checkerboard.
- colour  in  C_W  base colour.
- x0  in  X_W  rectangle left edge, inclusive.
- y0  in  Y_W  rectangle top edge, inclusive.
- x1  in  X_W  rectangle right edge, inclusive.
- y1  in  Y_W  rectangle bottom edge, inclusive.
- busy  out  1  high in LOAD and PLOT.
- done  out  1  fill complete.
- vga_x  out  X_W  pixel x to adapter.
- vga_y  out  Y_W  pixel y to adapter.
- vga_colour  out  C_W  pixel colour to adapter.
- vga_plot  out  1  write strobe to adapter.

Behaviour:
- General
  - All outputs are registered.
  - Reset (any state, including mid-fill) forces state IDLE and drives busy, done, vga_plot, vga_x, vga_y and vga_colour to 0 on the next edge.
- States: IDLE, LOAD, PLOT, DONE.
- IDLE
  - start=1 latches mode, colour, x0, y0, x1 and y1, then moves to LOAD.
  - Input changes after latching have no effect on the current fill.
- LOAD (one cycle, vga_plot=0)
  - Clip: xe = min(x1, SCREEN_W-1), ye = min(y1, SCREEN_H-1).
  - Rectangle is empty if x0 > xe or y0 > ye. Empty -> DONE with zero plots. Otherwise -> PLOT with counters at (x0, y0).
- PLOT
  - Each cycle drives vga_plot=1 with vga_x/vga_y set to the counters and vga_colour per mode.
  - Scan is column-major: y increments first; at ye, y wraps to y0 and x increments.
  - After pixel (xe, ye) is plotted, the next cycle goes to DONE with vga_plot=0.
- Timing
  - First vga_plot is 2 cycles after the edge that samples start.
  - Plot count is exactly (xe-x0+1)*(ye-y0+1); no gaps and no duplicates.
  - done rises the cycle after the last plot.
- Mode colours (all sums modulo 2^C_W)
  - Mode 0: colour.
  - Mode 1: x + colour. With colour=0 this reproduces the legacy fill, colour = x mod 8.
  - Mode 2: y + colour.
  - Mode 3: colour if ((x>>CHK_LOG) ^ (y>>CHK_LOG)) bit 0 is 0, else ~colour.
- DONE
  - done=1, busy=0.
  - Stays in DONE while start=1. When start=0 -> IDLE with done=0 next cycle.
  - A held start therefore never retriggers a fill.
- Abort
  - abort=1 in LOAD or PLOT -> IDLE next edge; vga_plot=0 that edge; done never asserts.
  - Abort is ignored in IDLE and DONE.
  - Simultaneous abort and last plot: abort wins and done is not asserted.
- Counter arithmetic must not overflow when xe = 2^X_W - 1; use an explicit last-column compare, not wrap detection.

Test Plan:
- Full screen: rst pulse, start=1, mode=1, colour=0, (0,0)-(159,119) -> exactly 19200 plots. Pixel (5,7) has colour 5; pixel (159,0) has colour 7; first plot (0,0) comes 2 cycles after start. done=1 holds until start drops, then clears next cycle.
- Small rect: mode=0, colour=4, (10,20)-(12,21) -> 6 plots in order (10,20), (10,21), (11,20), (11,21), (12,20), (12,21), all colour 4; done the cycle after (12,21).
- Clipping: x1=200, y1=127, x0=158, y0=118 -> plots only x in 158..159 and y in 118..119 (4 plots). Empty: x0=50, x1=40 -> zero plots, done 2 cycles after start.
- Checkerboard: mode=3, colour=2, full screen -> (0,0)=2, (8,0)=5, (8,8)=2, (7,15)=5.
- Abort/reset: abort at the 100th plot -> vga_plot=0 next cycle, no done, busy=0. Then restart and complete normally. Repeat using rst at the 100th plot -> all outputs 0.
- Retrigger guard: hold start=1 through DONE for 50 cycles -> no further plots; drop start, reassert -> new fill begins.
